// File: rtl/gigaexp_pkg.sv
// Shared types for the Gigatron expansion SPI logic.
// State encoding, port-select codes and bit-pick helpers.
package gigaexp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_TRAIL,
        S_DONE
    } spi_state_t;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_SPI0 = 2'b01;
    localparam logic [1:0] SEL_SPI1 = 2'b10;

    // Bit of a byte at a given shift position, in wire order.
    function automatic logic pick_bit(
        input logic [7:0] data,
        input logic [2:0] idx,
        input logic       msb_first
    );
        logic [2:0] pos;
        pos = msb_first ? (3'd7 - idx) : idx;
        return data[pos];
    endfunction

    // Active-low selects {nss1, nss0}; at most one is low.
    function automatic logic [1:0] nss_for(
        input logic [1:0] sel,
        input logic       en
    );
        logic [1:0] nss;
        nss[0] = ~(en && (sel == SEL_SPI0));
        nss[1] = ~(en && (sel == SEL_SPI1));
        return nss;
    endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Down-counter timing one SCK half-period.
// Pulses expire in the last cycle of each loaded phase.
module spi_phase_timer #(
    parameter int DIV = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic load,
    output logic expire
);

    localparam int W = $clog2(DIV + 1);
    localparam logic [W-1:0] RELOAD = W'(DIV - 1);

    logic [W-1:0] cnt;
    logic         armed;

    // Reload on request, count down once armed, disarm at zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt   <= '0;
            armed <= 1'b0;
        end else if (load) begin
            cnt   <= RELOAD;
            armed <= 1'b1;
        end else if (armed) begin
            if (cnt == '0) begin
                armed <= 1'b0;
            end else begin
                cnt <= cnt - W'(1);
            end
        end
    end

    assign expire = armed && (cnt == '0);

endmodule

// File: rtl/spi_byte_engine.sv
// SPI byte shifter driven by a single START pulse.
// Runs 8 bits of SCK/MOSI/nSSx and captures MISO.
module spi_byte_engine
    import gigaexp_pkg::*;
#(
    parameter int DIV       = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] TXDATA,
    input  logic [1:0] SEL,
    input  logic       CPOL,
    input  logic       HOLD,
    input  logic       MISO0,
    input  logic       MISO1,
    output logic       SCK,
    output logic       MOSI,
    output logic       nSS0,
    output logic       nSS1,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] RXDATA
);

    spi_state_t state;
    logic [7:0] tx_q;
    logic [7:0] rx_sh;
    logic [2:0] idx;
    logic       cpol_q;
    logic [1:0] sel_q;
    logic       expire;
    logic       accept;
    logic       load;
    logic       miso;

    assign accept = START &&
        ((state == S_IDLE) || (state == S_DONE));

    assign load = accept ||
        ((state == S_LEAD) && expire) ||
        ((state == S_TRAIL) && expire && (idx != 3'd7));

    spi_phase_timer #(
        .DIV(DIV)
    ) u_timer (
        .CLK   (CLK),
        .RST   (RST),
        .load  (load),
        .expire(expire)
    );

    // Selected data-in line; unselected bus reads as 1.
    always_comb begin
        miso = 1'b1;
        unique case (sel_q)
            SEL_SPI0: miso = MISO0;
            SEL_SPI1: miso = MISO1;
            default:  miso = 1'b1;
        endcase
    end

    // Transfer FSM with registered SPI pins and status.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= S_IDLE;
            tx_q   <= 8'h00;
            rx_sh  <= 8'h00;
            idx    <= 3'd0;
            cpol_q <= 1'b0;
            sel_q  <= SEL_NONE;
            SCK    <= 1'b0;
            MOSI   <= 1'b1;
            nSS0   <= 1'b1;
            nSS1   <= 1'b1;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
            RXDATA <= 8'h00;
        end else begin
            DONE <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        state  <= S_LEAD;
                        tx_q   <= TXDATA;
                        sel_q  <= SEL;
                        cpol_q <= CPOL;
                        idx    <= 3'd0;
                        SCK    <= CPOL;
                        MOSI   <= pick_bit(TXDATA, 3'd0,
                                           MSB_FIRST);
                        {nSS1, nSS0} <= nss_for(SEL, 1'b1);
                        BUSY   <= 1'b1;
                    end else begin
                        state <= S_IDLE;
                        SCK   <= cpol_q;
                        MOSI  <= 1'b1;
                        {nSS1, nSS0} <= nss_for(sel_q, HOLD);
                    end
                end
                S_LEAD: begin
                    if (expire) begin
                        state <= S_TRAIL;
                        SCK   <= ~cpol_q;
                        rx_sh <= MSB_FIRST ?
                            {rx_sh[6:0], miso} :
                            {miso, rx_sh[7:1]};
                    end
                end
                S_TRAIL: begin
                    if (expire) begin
                        SCK <= cpol_q;
                        if (idx == 3'd7) begin
                            state  <= S_DONE;
                            RXDATA <= rx_sh;
                            DONE   <= 1'b1;
                            BUSY   <= 1'b0;
                            {nSS1, nSS0} <= nss_for(sel_q, HOLD);
                        end else begin
                            state <= S_LEAD;
                            idx   <= idx + 3'd1;
                            MOSI  <= pick_bit(tx_q, idx + 3'd1,
                                              MSB_FIRST);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
